// File: rtl/udma_tx_chan_resp.sv
// udma_tx_chan_resp: single-channel uDMA TX responder reading L2 one word per granted beat
module udma_tx_chan_resp #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic                      eot_o,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [1:0]                data_datasize_i,
  output logic [31:0]               data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      l2_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
  input  logic                      l2_gnt_i,
  input  logic [31:0]               l2_rdata_i,
  input  logic                      l2_rvalid_i
);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, DATA} state_t;
  state_t state, state_nxt;
  logic [L2_AWIDTH_NOAL-1:0] r_addr, r_start_latched, pend_addr, ld_addr;
  logic [TRANS_SIZE-1:0]     r_left, r_size_latched, pend_size, ld_size, left_dec;
  logic                      r_cont, pend_cont, ld_cont, r_live;
  logic [2:0]                step, step_in;
  logic [1:0]                lane;
  logic [31:0]               mask;
  logic                      take, l2_hs, upd, last, new_ok, ld_in, ld, pend_fill;
  // beat grant, L2 handshake and end-of-transfer decode; r_live marks a beat that still counts toward the transfer
  always_comb begin
    step_in   = data_datasize_i == 2'd0 ? 3'd1 : data_datasize_i == 2'd1 ? 3'd2 : 3'd4;
    take      = state == IDLE && cfg_en_o && data_req_i && !cfg_clr_i;
    l2_hs     = l2_req_o && l2_gnt_i;
    upd       = l2_hs && r_live;
    last      = upd && r_left != '0 && r_left <= TRANS_SIZE'(step);
    left_dec  = r_left > TRANS_SIZE'(step) ? r_left - TRANS_SIZE'(step) : '0;
    new_ok    = cfg_en_i && cfg_size_i != '0;
    ld_in     = new_ok && (last ? !r_cont : !cfg_en_o);
    ld        = ld_in || (last && !r_cont && cfg_pending_o);
    pend_fill = new_ok && !ld_in;
    ld_addr   = ld_in ? cfg_startaddr_i : pend_addr;
    ld_size   = ld_in ? cfg_size_i : pend_size;
    ld_cont   = ld_in ? cfg_continuous_i : pend_cont;
    mask      = step[2] ? 32'hffff_ffff : step[1] ? 32'h0000_ffff : 32'h0000_00ff;
  end
  // transfer configuration, progress counters and pending slot; a clear overrides everything else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr          <= '0;
      r_left          <= '0;
      r_start_latched <= '0;
      r_size_latched  <= '0;
      r_cont          <= 1'b0;
      pend_addr       <= '0;
      pend_size       <= '0;
      pend_cont       <= 1'b0;
      cfg_en_o        <= 1'b0;
      cfg_pending_o   <= 1'b0;
      eot_o           <= 1'b0;
    end else if (cfg_clr_i) begin
      cfg_en_o      <= 1'b0;
      cfg_pending_o <= 1'b0;
      r_cont        <= 1'b0;
      r_left        <= '0;
      eot_o         <= 1'b0;
    end else begin
      eot_o <= last;
      if (upd) begin
        r_addr <= r_addr + L2_AWIDTH_NOAL'(step);
        r_left <= left_dec;
      end
      if (last && r_cont) begin
        r_addr <= r_start_latched;
        r_left <= r_size_latched;
      end
      if (last && !r_cont && !ld) cfg_en_o <= 1'b0;
      if (ld) begin
        r_addr          <= ld_addr;
        r_left          <= ld_size;
        r_start_latched <= ld_addr;
        r_size_latched  <= ld_size;
        r_cont          <= ld_cont;
        cfg_en_o        <= 1'b1;
      end
      if (pend_fill) begin
        pend_addr     <= cfg_startaddr_i;
        pend_size     <= cfg_size_i;
        pend_cont     <= cfg_continuous_i;
        cfg_pending_o <= 1'b1;
      end else if (last && !r_cont) cfg_pending_o <= 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: one beat travels grant -> L2 request -> L2 data -> peripheral handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = take ? RD_REQ : IDLE;
      RD_REQ:  state_nxt = l2_hs ? RD_WAIT : RD_REQ;
      RD_WAIT: state_nxt = l2_rvalid_i ? DATA : RD_WAIT;
      DATA:    state_nxt = data_ready_i ? IDLE : DATA;
      default: state_nxt = IDLE;
    endcase
  end
  // beat context captured at grant, aligned read data captured on rvalid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_gnt_o <= 1'b0;
      step       <= '0;
      lane       <= '0;
      l2_addr_o  <= '0;
      r_live     <= 1'b0;
      data_o     <= '0;
    end else begin
      data_gnt_o <= take;
      if (take) begin
        step      <= step_in;
        lane      <= r_addr[1:0];
        l2_addr_o <= {r_addr[L2_AWIDTH_NOAL-1:2], 2'b00};
        r_live    <= 1'b1;
      end else if (l2_hs || cfg_clr_i) r_live <= 1'b0;
      if (state == RD_WAIT && l2_rvalid_i) data_o <= (l2_rdata_i >> {lane, 3'b000}) & mask;
    end
  end
  // outputs: the L2 request waits out the grant-pulse cycle so it starts one cycle after data_gnt_o
  always_comb begin
    data_valid_o     = state == DATA;
    l2_req_o         = state == RD_REQ && !data_gnt_o;
    cfg_curr_addr_o  = r_addr;
    cfg_bytes_left_o = r_left;
  end
endmodule

// File: tb/tb_udma_tx_chan_resp.sv
// tb_udma_tx_chan_resp: directed plus randomized bench against a transfer-level reference model
module tb_udma_tx_chan_resp;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] cfg_startaddr_i = '0;
  logic [15:0] cfg_size_i = '0;
  logic        cfg_continuous_i = 1'b0, cfg_en_i = 1'b0, cfg_clr_i = 1'b0;
  logic        cfg_en_o, cfg_pending_o, eot_o;
  logic [11:0] cfg_curr_addr_o;
  logic [15:0] cfg_bytes_left_o;
  logic        data_req_i = 1'b0, data_gnt_o, data_valid_o, data_ready_i = 1'b0;
  logic [1:0]  data_datasize_i = '0;
  logic [31:0] data_o;
  logic        l2_req_o, l2_gnt_i, l2_rvalid_i;
  logic [11:0] l2_addr_o;
  logic [31:0] l2_rdata_i;

  udma_tx_chan_resp dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_continuous_i(cfg_continuous_i), .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
    .cfg_en_o(cfg_en_o), .cfg_pending_o(cfg_pending_o),
    .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o), .eot_o(eot_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_datasize_i(data_datasize_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_gnt_i(l2_gnt_i),
    .l2_rdata_i(l2_rdata_i), .l2_rvalid_i(l2_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:1023];
  int  rdelay = 1;
  bit  gnt_all = 1'b1;
  bit  rnd = 1'b0;

  // L2 memory: grant either always or randomly, return data rdelay cycles after the grant
  initial begin
    int rv_cnt;
    logic hs, rs;
    logic [11:0] a, ra;
    rv_cnt = 0;
    ra = '0;
    l2_gnt_i = 1'b0;
    l2_rvalid_i = 1'b0;
    l2_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      hs = l2_req_o & l2_gnt_i;
      rs = rst_i;
      a = l2_addr_o;
      @(posedge clk_i);
      #1;
      l2_rvalid_i = 1'b0;
      if (rs) rv_cnt = 0;
      else if (hs) begin
        ra = a;
        rv_cnt = rdelay;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          l2_rvalid_i = 1'b1;
          l2_rdata_i = mem[ra[11:2]];
        end
      end
      l2_gnt_i = gnt_all ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // reference model: transfer registers, pending slot and expected beat queue
  logic [11:0] m_addr = '0, m_start = '0, s_addr = '0, b_word = '0;
  logic [15:0] m_left = '0, m_size = '0, s_size = '0;
  logic        m_en = 0, m_pend = 0, m_cont = 0, s_cont = 0, m_live = 0;
  logic        owed = 0, outst = 0, p_gnt = 0, p_eot = 0, m_ok = 0;
  logic [2:0]  b_step = '0;
  logic [31:0] expq [$];
  logic [31:0] logq [$];
  int          eots = 0;

  always @(negedge clk_i) begin
    logic hs, vhs, last, new_ok;
    logic [2:0] st;
    logic [31:0] w;
    hs = l2_req_o & l2_gnt_i;
    vhs = data_valid_o & data_ready_i;
    if (m_ok) begin
      chk("gnt", 32'(data_gnt_o), 32'(p_gnt));
      chk("eot", 32'(eot_o), 32'(p_eot));
      chk("cfg_en", 32'(cfg_en_o), 32'(m_en));
      chk("pending", 32'(cfg_pending_o), 32'(m_pend));
      chk("curr_addr", 32'(cfg_curr_addr_o), 32'(m_addr));
      chk("bytes_left", 32'(cfg_bytes_left_o), 32'(m_left));
      chk("l2req_spurious", 32'(l2_req_o & ~owed), 32'd0);
      if (hs) chk("l2_addr", 32'(l2_addr_o), 32'(b_word));
      if (data_valid_o) begin
        if (expq.size() == 0) chk("valid_spurious", 32'(data_valid_o), 32'd0);
        else chk("data", data_o, expq[0]);
      end
      if (eot_o) eots++;
    end
    if (rst_i) begin
      {m_addr, m_start, s_addr, b_word} = '0;
      {m_left, m_size, s_size} = '0;
      {m_en, m_pend, m_cont, s_cont, m_live, owed, outst, p_gnt, p_eot} = '0;
      b_step = '0;
      expq.delete();
      m_ok = 1'b1;
    end else begin
      p_gnt = !outst && m_en && data_req_i && !cfg_clr_i;
      new_ok = cfg_en_i && cfg_size_i != 0;
      last = hs && m_live && m_left != 0 && m_left <= 16'(b_step);
      p_eot = last && !cfg_clr_i;
      if (hs) owed = 1'b0;
      if (cfg_clr_i) begin
        {m_en, m_pend, m_cont, m_live} = '0;
        m_left = '0;
      end else begin
        if (hs && m_live) begin
          m_addr = m_addr + 12'(b_step);
          m_left = m_left > 16'(b_step) ? m_left - 16'(b_step) : 16'd0;
          m_live = 1'b0;
        end
        if (last && m_cont) begin
          m_addr = m_start;
          m_left = m_size;
          if (new_ok) begin
            {s_addr, s_size, s_cont} = {cfg_startaddr_i, cfg_size_i, cfg_continuous_i};
            m_pend = 1'b1;
          end
        end else if (last || (new_ok && !m_en)) begin
          if (new_ok) begin
            {m_addr, m_left, m_cont} = {cfg_startaddr_i, cfg_size_i, cfg_continuous_i};
            {m_start, m_size, m_en} = {cfg_startaddr_i, cfg_size_i, 1'b1};
          end else if (m_pend) begin
            {m_addr, m_left, m_cont} = {s_addr, s_size, s_cont};
            {m_start, m_size, m_en} = {s_addr, s_size, 1'b1};
          end else m_en = 1'b0;
          if (last) m_pend = 1'b0;
        end else if (new_ok) begin
          {s_addr, s_size, s_cont} = {cfg_startaddr_i, cfg_size_i, cfg_continuous_i};
          m_pend = 1'b1;
        end
      end
      if (vhs && expq.size() > 0) begin
        logq.push_back(data_o);
        void'(expq.pop_front());
        outst = 1'b0;
      end
      if (p_gnt) begin
        st = data_datasize_i == 2'd0 ? 3'd1 : data_datasize_i == 2'd1 ? 3'd2 : 3'd4;
        b_step = st;
        b_word = {m_addr[11:2], 2'b00};
        w = mem[m_addr[11:2]] >> {m_addr[1:0], 3'b000};
        expq.push_back(st == 3'd1 ? w & 32'hff : st == 3'd2 ? w & 32'hffff : w);
        {outst, owed, m_live} = 3'b111;
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
    if (rnd) begin
      data_req_i = $urandom_range(0, 3) != 0;
      data_ready_i = $urandom_range(0, 2) != 0;
      data_datasize_i = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic start(input logic [11:0] a, input logic [15:0] s, input logic c);
    cfg_startaddr_i = a;
    cfg_size_i = s;
    cfg_continuous_i = c;
    cfg_en_i = 1'b1;
    tick;
    cfg_en_i = 1'b0;
  endtask

  task automatic clear;
    cfg_clr_i = 1'b1;
    tick;
    cfg_clr_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_en || outst || cfg_en_o) && n < budget) begin
      tick;
      n++;
    end
    chk("idle_wait", {30'd0, m_en, outst}, 32'd0);
  endtask

  task automatic fresh;
    logq.delete();
    eots = 0;
  endtask

  initial begin
    logic [31:0] exp_b [4];
    logic [31:0] d;
    int n;
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_b [4];
    logic [31:0] d;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[12'h010 >> 2] = 32'h4433_2211;
    mem[12'h100 >> 2] = 32'h4433_2211;
    mem[12'h104 >> 2] = 32'haabb_0011;
    repeat (3) tick;
    rst_i = 1'b0;
    chk("rst_en", 32'(cfg_en_o), 32'd0);
    chk("rst_gnt", 32'(data_gnt_o), 32'd0);
    chk("rst_l2req", 32'(l2_req_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    data_req_i = 1'b1;
    data_ready_i = 1'b1;

    fresh;
    data_datasize_i = 2'd0;
    start(12'h010, 16'd4, 1'b0);
    wait_idle(200);
    exp_b = '{32'h11, 32'h22, 32'h33, 32'h44};
    chk("basic_n", 32'(logq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("basic_beat", logq.size() > i ? logq[i] : 32'hdead, exp_b[i]);
    chk("basic_eots", 32'(eots), 32'd1);
    chk("basic_en", 32'(cfg_en_o), 32'd0);

    fresh;
    data_datasize_i = 2'd1;
    start(12'h102, 16'd3, 1'b0);
    chk("mis_left0", 32'(cfg_bytes_left_o), 32'd3);
    wait_idle(200);
    chk("mis_b0", logq.size() > 0 ? logq[0] : 32'hdead, 32'h4433);
    chk("mis_b1", logq.size() > 1 ? logq[1] : 32'hdead, 32'h0011);

    fresh;
    data_datasize_i = 2'd2;
    start(12'h020, 16'd8, 1'b1);
    n = 0;
    while (eots < 4 && n < 400) begin
      tick;
      n++;
    end
    chk("cont_eots", 32'(eots), 32'd4);
    chk("cont_en", 32'(cfg_en_o), 32'd1);
    clear;
    chk("cont_clr", 32'(cfg_en_o), 32'd0);
    wait_idle(200);

    fresh;
    data_datasize_i = 2'd0;
    start(12'h040, 16'd4, 1'b0);
    repeat (2) tick;
    start(12'h200, 16'd4, 1'b0);
    chk("pend_set", 32'(cfg_pending_o), 32'd1);
    n = 0;
    while (!eot_o && n < 200) begin
      tick;
      n++;
    end
    chk("pend_eot_seen", 32'(eot_o), 32'd1);
    chk("pend_addr", 32'(cfg_curr_addr_o), 32'h200);
    chk("pend_clr", 32'(cfg_pending_o), 32'd0);
    wait_idle(300);
    chk("pend_beat", logq.size() > 4 ? logq[4] : 32'hdead, mem[12'h200 >> 2] & 32'hff);

    fresh;
    data_datasize_i = 2'd2;
    data_ready_i = 1'b0;
    start(12'h300, 16'd8, 1'b0);
    n = 0;
    while (!data_valid_o && n < 100) begin
      tick;
      n++;
    end
    d = data_o;
    chk("bp_data", d, mem[12'h300 >> 2]);
    repeat (5) begin
      tick;
      chk("bp_hold", data_o, d);
      chk("bp_valid", 32'(data_valid_o), 32'd1);
      chk("bp_gnt", 32'(data_gnt_o), 32'd0);
      chk("bp_l2req", 32'(l2_req_o), 32'd0);
    end
    data_ready_i = 1'b1;
    wait_idle(200);

    fresh;
    rdelay = 5;
    data_datasize_i = 2'd0;
    start(12'h010, 16'd4, 1'b0);
    n = 0;
    while (!l2_req_o && n < 50) begin
      tick;
      n++;
    end
    tick;
    clear;
    chk("clr_en", 32'(cfg_en_o), 32'd0);
    repeat (20) tick;
    chk("clr_beats", 32'(logq.size()), 32'd1);
    chk("clr_beat0", logq.size() > 0 ? logq[0] : 32'hdead, 32'h11);
    chk("clr_eots", 32'(eots), 32'd0);
    rdelay = 1;

    start(12'h050, 16'd0, 1'b0);
    tick;
    chk("zero_en", 32'(cfg_en_o), 32'd0);
    chk("zero_left", 32'(cfg_bytes_left_o), 32'd0);

    start(12'h060, 16'd12, 1'b0);
    repeat (6) tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("mrst_en", 32'(cfg_en_o), 32'd0);
    chk("mrst_valid", 32'(data_valid_o), 32'd0);
    chk("mrst_left", 32'(cfg_bytes_left_o), 32'd0);
    chk("mrst_l2req", 32'(l2_req_o), 32'd0);
    repeat (8) tick;

    rnd = 1'b1;
    gnt_all = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rdelay = $urandom_range(1, 3);
      start(12'($urandom), 16'($urandom_range(0, 10)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 15)) tick;
        start(12'($urandom), 16'($urandom_range(1, 6)), 1'b0);
      end
      wait_idle(2000);
    end
    rnd = 1'b0;
    repeat (4) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
